// File: rtl/coin_acceptor_pkg.sv
// rtl/coin_acceptor_pkg.sv - shared coin codes, FSM state type and helpers
// Exports: COIN_NONE/COIN_A/COIN_B/COIN_C one-hot codes, state_e, is_one_hot().
package coin_acceptor_pkg;

   localparam logic [2:0] COIN_NONE = 3'b000;
   localparam logic [2:0] COIN_A    = 3'b001;
   localparam logic [2:0] COIN_B    = 3'b010;
   localparam logic [2:0] COIN_C    = 3'b100;

   typedef enum logic [2:0] {
      IDLE         = 3'd0,
      DEBOUNCE     = 3'd1,
      EMIT         = 3'd2,
      REJECT       = 3'd3,
      WAIT_RELEASE = 3'd4
   } state_e;

   function automatic logic is_one_hot(input logic [2:0] v);
      return (v == COIN_A) || (v == COIN_B) || (v == COIN_C);
   endfunction

endpackage

// File: rtl/coin_acceptor_if.sv
// rtl/coin_acceptor_if.sv - sensor/coin bundle between vending front-end and acceptor
// sense[2:0], accept_en : driven by master (sensors / machine control)
// coin[2:0], coin_valid, reject, busy, coin_count[CNT_W-1:0] : driven by slave (acceptor)
interface coin_acceptor_if #(
   parameter int CNT_W = 8
);
   logic [2:0]       sense;
   logic             accept_en;
   logic [2:0]       coin;
   logic             coin_valid;
   logic             reject;
   logic             busy;
   logic [CNT_W-1:0] coin_count;

   modport master (
      output sense, accept_en,
      input  coin, coin_valid, reject, busy, coin_count
   );

   modport slave (
      input  sense, accept_en,
      output coin, coin_valid, reject, busy, coin_count
   );
endinterface

// File: rtl/coin_acceptor_sync2.sv
// rtl/coin_acceptor_sync2.sv - generic two-flop synchroniser
// clk : clock, rst : async active-low reset, d : async input, q : synchronised output
module sync2 #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);
   logic [WIDTH-1:0] meta_q, meta_d;
   logic [WIDTH-1:0] sync_q, sync_d;

   always_comb begin
      meta_d = d;
      sync_d = meta_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign q = sync_q;
endmodule

// File: rtl/coin_acceptor.sv
// rtl/coin_acceptor.sv - synchronise, debounce and validate coin sensors into a one-hot coin code
// clk : system clock, rst : async active-low reset
// bus.sense/accept_en in; bus.coin/coin_valid/reject/busy/coin_count out (all registered)
module coin_acceptor
   import coin_acceptor_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int PULSE_CYCLES    = 1,
   parameter int CNT_W           = 8
) (
   input  logic               clk,
   input  logic               rst,
   coin_acceptor_if.slave     bus
);
   localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int PL_W = $clog2(PULSE_CYCLES + 1);
   localparam logic [DB_W-1:0] DB_LOAD = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [PL_W-1:0] PL_LOAD = PL_W'(PULSE_CYCLES - 1);

   logic [2:0]       s;
   state_e           state_q, state_d;
   logic [2:0]       pat_q, pat_d;
   logic [DB_W-1:0]  dcnt_q, dcnt_d;
   logic [PL_W-1:0]  pcnt_q, pcnt_d;
   logic [2:0]       coin_q, coin_d;
   logic             valid_q, valid_d;
   logic             reject_q, reject_d;
   logic             busy_q, busy_d;
   logic [CNT_W-1:0] count_q, count_d;

   sync2 #(.WIDTH(3)) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (bus.sense),
      .q   (s)
   );

   always_comb begin
      state_d = state_q;
      pat_d   = pat_q;
      dcnt_d  = dcnt_q;
      pcnt_d  = pcnt_q;
      count_d = count_q;

      case (state_q)
         IDLE: begin
            if (s != 3'b000) begin
               state_d = DEBOUNCE;
               pat_d   = s;
               dcnt_d  = DB_LOAD;
            end
         end
         DEBOUNCE: begin
            // Any change of the pattern, including a release, kills the event.
            if (s != pat_q) begin
               state_d = REJECT;
            end else if (dcnt_q == '0) begin
               if (is_one_hot(pat_q) && bus.accept_en) begin
                  state_d = EMIT;
                  pcnt_d  = PL_LOAD;
                  // Counted on entry so a long pulse still counts once.
                  if (count_q != '1) begin
                     count_d = count_q + CNT_W'(1);
                  end
               end else begin
                  state_d = REJECT;
               end
            end else begin
               dcnt_d = dcnt_q - DB_W'(1);
            end
         end
         EMIT: begin
            if (pcnt_q == '0) begin
               state_d = WAIT_RELEASE;
            end else begin
               pcnt_d = pcnt_q - PL_W'(1);
            end
         end
         REJECT: begin
            state_d = WAIT_RELEASE;
         end
         WAIT_RELEASE: begin
            if (s == 3'b000) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Outputs are decoded from the next state so they line up with state_q.
      coin_d   = (state_d == EMIT) ? pat_q : COIN_NONE;
      valid_d  = (state_d == EMIT);
      reject_d = (state_d == REJECT);
      busy_d   = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         pat_q    <= '0;
         dcnt_q   <= '0;
         pcnt_q   <= '0;
         coin_q   <= COIN_NONE;
         valid_q  <= 1'b0;
         reject_q <= 1'b0;
         busy_q   <= 1'b0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         pat_q    <= pat_d;
         dcnt_q   <= dcnt_d;
         pcnt_q   <= pcnt_d;
         coin_q   <= coin_d;
         valid_q  <= valid_d;
         reject_q <= reject_d;
         busy_q   <= busy_d;
         count_q  <= count_d;
      end
   end

   assign bus.coin       = coin_q;
   assign bus.coin_valid = valid_q;
   assign bus.reject     = reject_q;
   assign bus.busy       = busy_q;
   assign bus.coin_count = count_q;
endmodule

// File: tb/tb_coin_acceptor.sv
// tb/tb_coin_acceptor.sv - self-checking bench for coin_acceptor
module tb_coin_acceptor;
   import coin_acceptor_pkg::*;

   localparam int D = 4;

   logic clk = 1'b0;
   logic rst_a, rst_b;
   always #5 clk = ~clk;

   coin_acceptor_if #(.CNT_W(8)) bus_a ();
   coin_acceptor_if #(.CNT_W(2)) bus_b ();

   coin_acceptor #(.DEBOUNCE_CYCLES(D), .PULSE_CYCLES(1), .CNT_W(8)) dut_a (
      .clk (clk),
      .rst (rst_a),
      .bus (bus_a)
   );

   coin_acceptor #(.DEBOUNCE_CYCLES(D), .PULSE_CYCLES(4), .CNT_W(2)) dut_b (
      .clk (clk),
      .rst (rst_b),
      .bus (bus_b)
   );

   int errors = 0;
   int checks = 0;
   int model_cnt [2];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input int inst, input logic [2:0] p, input logic a);
      if (inst == 0) begin
         bus_a.sense = p; bus_a.accept_en = a;
      end else begin
         bus_b.sense = p; bus_b.accept_en = a;
      end
   endtask

   task automatic sample(input int inst, output logic [2:0] c, output logic v,
                         output logic r, output logic b, output logic [31:0] cnt);
      if (inst == 0) begin
         c = bus_a.coin; v = bus_a.coin_valid; r = bus_a.reject; b = bus_a.busy;
         cnt = 32'(bus_a.coin_count);
      end else begin
         c = bus_b.coin; v = bus_b.coin_valid; r = bus_b.reject; b = bus_b.busy;
         cnt = 32'(bus_b.coin_count);
      end
   endtask

   // Reference: one event = pattern p held for L cycles then released.
   // Accepted iff p is one-hot, accept_en is 1 and L >= D+1; coin then appears
   // 2 (sync) + D + 1 cycles after the drive cycle, for the instance's pulse width.
   // Every other non-zero event produces exactly one reject pulse.
   task automatic run_event(input string name, input int inst, input logic [2:0] p,
                            input int L, input logic a, output int last_busy);
      int pw, mx, n_rej, n_coin, first, viol;
      logic [2:0] cor, co;
      logic v, r, b;
      logic [31:0] cnt;
      logic acc;
      pw = (inst == 0) ? 1 : 4;
      mx = (inst == 0) ? 255 : 3;
      n_rej = 0; n_coin = 0; first = -1; viol = 0; cor = 3'b000; last_busy = -1;
      for (int c = 0; c < L + D + pw + 10; c++) begin
         @(posedge clk);
         #1;
         drive(inst, (c < L) ? p : 3'b000, a);
         @(negedge clk);
         sample(inst, co, v, r, b, cnt);
         if (r) n_rej++;
         if (co != 3'b000) begin
            n_coin++;
            cor |= co;
            if (first < 0) first = c;
         end
         if (v !== (co != 3'b000)) viol++;
         if (b) last_busy = c;
      end
      acc = ($countones(p) == 1) && a && (L >= D + 1);
      if (acc && model_cnt[inst] < mx) model_cnt[inst]++;
      check({name, " rejects"}, n_rej, (p != 3'b000 && !acc) ? 1 : 0);
      check({name, " coin_cycles"}, n_coin, acc ? pw : 0);
      check({name, " coin_value"}, cor, acc ? p : 3'b000);
      if (acc) check({name, " latency"}, first, D + 3);
      check({name, " valid_vs_coin"}, viol, 0);
      check({name, " coin_count"}, cnt, model_cnt[inst]);
      check({name, " busy_end"}, b, 0);
   endtask

   initial begin
      int lb, found, pulses, L;
      logic [2:0] co, p;
      logic v, r, b, a;
      logic [31:0] cnt;

      model_cnt[0] = 0;
      model_cnt[1] = 0;
      rst_a = 1'b0; rst_b = 1'b0;
      drive(0, 3'b000, 1'b1);
      drive(1, 3'b000, 1'b1);
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         sample(i, co, v, r, b, cnt);
         check($sformatf("reset%0d coin", i), co, 3'b000);
         check($sformatf("reset%0d valid", i), v, 0);
         check($sformatf("reset%0d reject", i), r, 0);
         check($sformatf("reset%0d busy", i), b, 0);
         check($sformatf("reset%0d count", i), cnt, 0);
      end
      rst_a = 1'b1; rst_b = 1'b1;
      repeat (2) @(negedge clk);

      // Clean coin B, then busy must fall 3 cycles after release (last high at L+2).
      run_event("t1", 0, COIN_B, 10, 1'b1, lb);
      check("t1 busy_fall", lb, 12);
      // Multi-hot pattern.
      run_event("t2", 0, 3'b101, 10, 1'b1, lb);
      // Short glitch then a clean coin A.
      run_event("t3 glitch", 0, COIN_C, 2, 1'b1, lb);
      run_event("t3 clean", 0, COIN_A, 10, 1'b1, lb);
      // accept_en gating.
      run_event("t4 disabled", 0, COIN_A, 10, 1'b0, lb);
      run_event("t4 enabled", 0, COIN_A, 10, 1'b1, lb);
      // Boundary: exactly D and D+1 cycles of stable sense.
      run_event("len_D", 0, COIN_B, D, 1'b1, lb);
      run_event("len_D1", 0, COIN_B, D + 1, 1'b1, lb);

      // Randomised events against the reference.
      for (int i = 0; i < 20; i++) begin
         p = 3'($urandom_range(0, 7));
         L = $urandom_range(1, 9);
         a = ($urandom_range(0, 3) != 0);
         run_event($sformatf("rnd%0d", i), 0, p, L, a, lb);
      end

      // Saturating 2-bit counter on the second instance: 1,2,3,3,3.
      for (int i = 0; i < 5; i++) begin
         run_event($sformatf("t5 coin%0d", i), 1, COIN_C, 8, 1'b1, lb);
      end

      // Reset during a 4-cycle emit pulse.
      @(posedge clk);
      #1;
      drive(1, COIN_B, 1'b1);
      found = 0;
      for (int c = 0; c < 30 && found == 0; c++) begin
         @(negedge clk);
         if (bus_b.coin_valid) found = 1;
      end
      check("t6 first_emit", found, 1);
      @(posedge clk);
      #2;
      rst_b = 1'b0;
      #1;
      sample(1, co, v, r, b, cnt);
      check("t6 rst coin", co, 3'b000);
      check("t6 rst valid", v, 0);
      check("t6 rst busy", b, 0);
      check("t6 rst count", cnt, 0);
      model_cnt[1] = 0;
      @(negedge clk);
      rst_b = 1'b1;
      found = 0;
      for (int c = 0; c < 30 && found == 0; c++) begin
         @(negedge clk);
         if (bus_b.coin_valid) found = 1;
      end
      check("t6 re_emit", found, 1);
      check("t6 re_emit coin", bus_b.coin, COIN_B);
      pulses = 0;
      for (int c = 0; c < 10; c++) begin
         if (bus_b.coin_valid) pulses++;
         @(negedge clk);
      end
      check("t6 re_emit width", pulses, 4);
      check("t6 count", bus_b.coin_count, 1);
      drive(1, 3'b000, 1'b1);
      repeat (6) @(negedge clk);
      check("t6 busy_end", bus_b.busy, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/coin_acceptor.md
Name: coin_acceptor

Overview:
- Front-end stage that turns three raw, asynchronous coin-sensor lines into the clean one-hot coin code consumed by the vending machine's coin input `i[2:0]`.
- Coin codes: 3'b001 = coin A, 3'b010 = coin B, 3'b100 = coin C.
- Synchronises, debounces and validates (exactly one sensor active), then emits the code for a fixed number of cycles.
- Rejects ambiguous or too-short events and locks out until all sensors release.

Parameters:
- DEBOUNCE_CYCLES, 4: cycles the sensor pattern must stay stable before acceptance (must be ≥1).
- PULSE_CYCLES, 1: cycles the one-hot code is held on `coin` after acceptance (must be ≥1).
- CNT_W, 8: width of the saturating accepted-coin counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- sense  input  3  raw coin sensors, asynchronous to clk, active-high.
- accept_en  input  1  1 = coins accepted; 0 = every event is rejected.
- coin  output  3  one-hot coin code to the vending machine; 3'b000 when idle.
- coin_valid  output  1  high exactly while coin != 0.
- reject  output  1  one-cycle pulse per rejected event.
- busy  output  1  high in any state other than IDLE.
- coin_count  output  CNT_W  accepted coins since reset, saturates at all-ones.

Behaviour:
- Reset (rst=0, asynchronous):
  - coin=0, coin_valid=0, reject=0, busy=0, coin_count=0.
  - Synchroniser flops cleared; state=IDLE.
  - Reset asserted mid-operation aborts immediately; no pulse is emitted after release.
- Synchroniser: two-flop per bit. `s` denotes the synchronised 3-bit value, which lags `sense` by 2 cycles.
- IDLE:
  - s==0 -> stay.
  - s!=0 -> DEBOUNCE; capture pat=s; load debounce counter with DEBOUNCE_CYCLES-1.
- DEBOUNCE:
  - s!=pat -> REJECT.
  - s==pat and counter==0 -> evaluate:
    - one-hot pat and accept_en=1 -> EMIT.
    - otherwise (multi-hot or accept_en=0) -> REJECT.
  - else decrement the counter.
  - accept_en is sampled only at evaluation.
- EMIT:
  - coin=pat and coin_valid=1 for exactly PULSE_CYCLES cycles, starting the cycle after the evaluation cycle.
  - coin_count increments once, on the first EMIT cycle, unless saturated.
  - Exit to WAIT_RELEASE.
- REJECT:
  - reject=1 for one cycle, coin stays 0.
  - -> WAIT_RELEASE.
- WAIT_RELEASE:
  - Stay while s!=0; return to IDLE on the first cycle with s==0.
  - Sensor changes during WAIT_RELEASE never produce a second coin.
- Latency: with a stable one-hot sensor, coin asserts 2 (sync) + DEBOUNCE_CYCLES + 1 cycles after the sensor's rising-edge sample.
- Outputs are registered; no combinational path from sense or accept_en to any output.
- busy=1 in DEBOUNCE, EMIT, REJECT and WAIT_RELEASE.
- Counter saturation: at all-ones, further accepted coins still emit but coin_count holds.
- A glitch shorter than DEBOUNCE_CYCLES that returns to 0 -> REJECT (reject pulse), then IDLE.

Decomposition:
- Shared package:
  - Coin code constants COIN_A=3'b001, COIN_B=3'b010, COIN_C=3'b100, COIN_NONE=3'b000 (shared with the vending machine).
  - State enum {IDLE, DEBOUNCE, EMIT, REJECT, WAIT_RELEASE}.
- Sub-module: sync2, a generic 2-flop synchroniser (width parameter, same clk/rst), instantiated once with width 3.
- Everything else lives in the top.

Test Plan:
1. Reset, then sense=3'b010 held 10 cycles (defaults) -> coin=3'b010 and coin_valid=1 for 1 cycle at cycle 7 after the sense sample; coin_count=1; reject never asserts; busy drops after sense returns to 0 plus 3 cycles.
2. sense=3'b101 held 10 cycles -> reject pulses once; coin stays 0; coin_count unchanged.
3. sense=3'b100 for 2 cycles then 0 -> one reject pulse, no coin, FSM back in IDLE; a following clean 3'b001 is accepted with coin=3'b001.
4. accept_en=0 with clean sense=3'b001 -> reject pulse, no coin; repeat with accept_en=1 -> coin=3'b001.
5. Override CNT_W=2 and insert 5 clean coins -> coin_count reads 1,2,3,3,3; all 5 coin pulses present.
6. rst driven low during EMIT (PULSE_CYCLES=4) -> coin=0 immediately (asynchronous), coin_count=0; with sense still high after reset release, the held pattern is debounced afresh and emits again.
